nlc_sample_sequencer: RTL and testbench
=======================================

Name: nlc_sample_sequencer

Overview:
Front-end sequencer that buffers free-running ADC samples and drives the single-channel NLC engine one sample at a time over its srdyi/srdyo handshake. It captures each corrected result and presents it downstream together with the raw sample. It is the initiator/consumer end of the NLC sample interface. It also detects a hung engine by timeout and recovers it.

Parameters:
FIFO_DEPTH, 8, sample FIFO entries (power of 2, >=2)
ADDR_W, 3, log2(FIFO_DEPTH)
TIMEOUT_CYCLES, 1023, max cycles in WAIT before declaring the NLC hung
TO_W, 10, width of timeout counter (must hold TIMEOUT_CYCLES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset; clock clk
adc_valid  in  1  ADC sample strobe, one sample per high cycle
adc_data  in  21  ADC sample, two's complement
in_ready  out  1  FIFO not full (registered-state derived)
fifo_level  out  ADDR_W+1  current FIFO occupancy
drop_count  out  8  saturating count of samples dropped on full
nlc_srdyi  out  1  one-cycle request pulse to NLC
nlc_x_adc  out  21  sample presented to NLC, held stable from ISSUE until next ISSUE
nlc_srdyo  in  1  NLC result-valid pulse
nlc_x_lin  in  21  NLC corrected result
nlc_rst  out  1  NLC recovery reset, active-high
out_valid  out  1  one-cycle result strobe
out_data  out  21  corrected sample (raw sample on timeout)
out_raw  out  21  original sample for this result
timeout_err  out  1  one-cycle pulse coincident with out_valid on timeout
busy  out  1  FSM not in IDLE

Behaviour:
- Reset values:
  - All outputs 0; in_ready 1.
  - FIFO flushed, drop_count 0, FSM in IDLE, timer 0.
  - Reset mid-operation abandons the in-flight sample: no out_valid, no nlc_rst pulse from this block.
- FIFO write rule:
  - adc_valid writes when not full, or when full and a pop occurs the same cycle (pop happens in ISSUE).
  - Otherwise the sample is dropped; drop_count increments and saturates at 255.
  - Writes take effect at the clock edge; fifo_level reflects the registered state.
- FSM states: IDLE, ISSUE, WAIT, GAP, RECOVER.
  - IDLE: if FIFO non-empty -> ISSUE.
  - ISSUE (1 cycle):
    - nlc_srdyi=1 and nlc_x_adc=FIFO head, combinationally from head.
    - Pop; latch head into raw register; clear timer -> WAIT.
  - WAIT:
    - nlc_srdyo=1 -> register nlc_x_lin into out_data, raw into out_raw, out_valid=1 next cycle -> GAP.
    - Else timer increments; when timer==TIMEOUT_CYCLES -> out_valid=1, out_data=raw, out_raw=raw, timeout_err=1 next cycle -> RECOVER.
    - nlc_srdyo in the same cycle as expiry: nlc_srdyo wins, no timeout.
  - GAP (1 cycle): guarantees the NLC returns to its idle state before the next request -> IDLE.
  - RECOVER: nlc_rst=1 for exactly 2 cycles -> GAP.
- nlc_srdyo outside WAIT is ignored: no output, no state change.
- Latency:
  - adc_valid at cycle 0 into an empty FIFO with FSM IDLE -> nlc_srdyi at cycle 2.
  - out_valid one cycle after nlc_srdyo.
  - Minimum issue-to-issue spacing = NLC latency + 3 cycles.
- Ordering: results are emitted strictly in FIFO order; at most one sample is in flight.
- Data is passed bit-exact, 21-bit; no sign extension or arithmetic on samples.
- Pointers are ADDR_W bits and wrap modulo FIFO_DEPTH; the extra level bit distinguishes full from empty.

Test Plan:
1. Single sample: NLC model returns x+5 after 40 cycles.
   - adc_data=0x00010 at cycle 0 -> nlc_srdyi at cycle 2 with nlc_x_adc=0x00010.
   - nlc_srdyo at cycle 42 -> out_valid at cycle 43, out_data=0x00015, out_raw=0x00010, timeout_err=0.
2. Burst: 10 consecutive adc_valid cycles 0..9 (values 1..10) with NLC latency 40.
   - Sample 10 dropped, drop_count=1, in_ready=0 during cycle 9.
   - Nine outputs 6..14 in order, each out_valid >=43 cycles apart.
3. Timeout: NLC never asserts srdyo.
   - out_valid with out_data=out_raw=sample and timeout_err=1, exactly 1024 cycles after ISSUE+1.
   - nlc_rst high for 2 cycles, then the next queued sample issues 4 cycles after out_valid.
4. Race: nlc_srdyo on the cycle the timer reaches TIMEOUT_CYCLES -> normal result, timeout_err=0, nlc_rst never asserted.
5. Spurious/negative data:
   - nlc_srdyo pulsed in IDLE -> no out_valid.
   - Sample 0x1FFFFF with model identity -> out_data=0x1FFFFF.
6. Reset mid-WAIT with 3 samples queued:
   - fifo_level=0, busy=0, no out_valid, drop_count=0.
   - A new sample after reset behaves as scenario 1.

Source files
------------

// File: rtl/nlc_sample_sequencer.sv
// nlc_sample_sequencer
// Buffers free-running ADC samples in a small FIFO and feeds them one at a time
// to the NLC engine over the srdyi/srdyo handshake. Each corrected result is
// returned downstream with its raw sample. A hung engine is detected by
// timeout: the raw sample is passed through and the engine is reset.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a buffered sample
// S_ISSUE   | one-cycle request to the NLC, FIFO head popped
// S_WAIT    | waiting for the NLC result, timeout timer running
// S_GAP     | one idle cycle so the NLC settles before the next request
// S_RECOVER | two-cycle NLC reset after a timeout
module nlc_sample_sequencer #(
  parameter int FIFO_DEPTH     = 8,
  parameter int ADDR_W         = 3,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_W           = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            adc_valid,
  input  logic [20:0]     adc_data,
  output logic            in_ready,
  output logic [ADDR_W:0] fifo_level,
  output logic [7:0]      drop_count,
  output logic            nlc_srdyi,
  output logic [20:0]     nlc_x_adc,
  input  logic            nlc_srdyo,
  input  logic [20:0]     nlc_x_lin,
  output logic            nlc_rst,
  output logic            out_valid,
  output logic [20:0]     out_data,
  output logic [20:0]     out_raw,
  output logic            timeout_err,
  output logic            busy
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_GAP, S_RECOVER} state_t;

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(FIFO_DEPTH);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);

  state_t            state_q, state_d;
  logic [20:0]       mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [7:0]        drop_q, drop_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic              rec_q, rec_d;
  logic [20:0]       raw_q, raw_d;
  logic              out_valid_q, out_valid_d;
  logic              timeout_q, timeout_d;
  logic [20:0]       out_data_q, out_data_d;
  logic [20:0]       out_raw_q, out_raw_d;
  logic              full, empty, push, pop, expired;
  logic [20:0]       head;

  assign full    = (level_q == LVL_FULL);
  assign empty   = (level_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign pop     = (state_q == S_ISSUE);
  // a full FIFO still accepts a sample in the cycle its head is popped
  assign push    = adc_valid && (!full || pop);
  assign expired = (timer_q == TO_LIMIT);

  assign in_ready    = !full;
  assign fifo_level  = level_q;
  assign drop_count  = drop_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_raw     = out_raw_q;
  assign timeout_err = timeout_q;

  // sample storage; validity is tracked by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= adc_data;
  end

  // occupancy and saturating drop count next-state
  always_comb begin
    level_d = level_q;
    if (push && !pop)      level_d = level_q + (ADDR_W+1)'(1);
    else if (pop && !push) level_d = level_q - (ADDR_W+1)'(1);
    drop_d = drop_q;
    if (adc_valid && !push && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  // FIFO pointers, occupancy and drop counter
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level_q <= level_d;
      drop_q  <= drop_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state; a result arriving on the expiry cycle beats the timeout
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!empty) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_WAIT;
      S_WAIT:    if (nlc_srdyo)    state_d = S_GAP;
                 else if (expired) state_d = S_RECOVER;
      S_GAP:     state_d = S_IDLE;
      S_RECOVER: if (rec_q) state_d = S_GAP;
      default:   state_d = S_IDLE;
    endcase
  end

  // FSM outputs; the request sample comes straight from the head in ISSUE
  // and is then held from the raw register until the next request
  always_comb begin
    nlc_srdyi = (state_q == S_ISSUE);
    nlc_x_adc = (state_q == S_ISSUE) ? head : raw_q;
    nlc_rst   = (state_q == S_RECOVER);
    busy      = (state_q != S_IDLE);
  end

  // datapath next-state: raw capture, timeout timer and result registers
  always_comb begin
    timer_d     = timer_q;
    rec_d       = 1'b0;
    raw_d       = raw_q;
    out_valid_d = 1'b0;
    timeout_d   = 1'b0;
    out_data_d  = out_data_q;
    out_raw_d   = out_raw_q;
    unique case (state_q)
      S_ISSUE: begin
        raw_d   = head;
        timer_d = '0;
      end
      S_WAIT: begin
        if (nlc_srdyo) begin
          out_valid_d = 1'b1;
          out_data_d  = nlc_x_lin;
          out_raw_d   = raw_q;
        end else if (expired) begin
          out_valid_d = 1'b1;
          timeout_d   = 1'b1;
          out_data_d  = raw_q;
          out_raw_d   = raw_q;
        end else begin
          timer_d = timer_q + TO_W'(1);
        end
      end
      S_RECOVER: rec_d = !rec_q;
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_q     <= '0;
      rec_q       <= 1'b0;
      raw_q       <= '0;
      out_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      out_data_q  <= '0;
      out_raw_q   <= '0;
    end else begin
      timer_q     <= timer_d;
      rec_q       <= rec_d;
      raw_q       <= raw_d;
      out_valid_q <= out_valid_d;
      timeout_q   <= timeout_d;
      out_data_q  <= out_data_d;
      out_raw_q   <= out_raw_d;
    end
  end

endmodule

// File: tb/tb_nlc_sample_sequencer.sv
// Bench for nlc_sample_sequencer: a timestamp-based reference model checks
// every output on every cycle, a table of single-sample transactions checks
// latency/data/timeout behaviour, and hand-written sequences cover burst
// overflow, timeout recovery, spurious results and reset mid-transaction.
module tb_nlc_sample_sequencer;
  localparam int TO    = 1023;
  localparam int NEVER = -1;
  localparam int FAR   = 32'h7fffffff;

  logic        clk, reset, adc_valid, nlc_srdyo;
  logic [20:0] adc_data, nlc_x_lin;
  logic        in_ready;
  logic [3:0]  fifo_level;
  logic [7:0]  drop_count;
  logic        nlc_srdyi, nlc_rst, out_valid, timeout_err, busy;
  logic [20:0] nlc_x_adc, out_data, out_raw;

  nlc_sample_sequencer #(.FIFO_DEPTH(8), .ADDR_W(3), .TIMEOUT_CYCLES(TO), .TO_W(10)) dut (
    .clk(clk), .reset(reset), .adc_valid(adc_valid), .adc_data(adc_data),
    .in_ready(in_ready), .fifo_level(fifo_level), .drop_count(drop_count),
    .nlc_srdyi(nlc_srdyi), .nlc_x_adc(nlc_x_adc), .nlc_srdyo(nlc_srdyo),
    .nlc_x_lin(nlc_x_lin), .nlc_rst(nlc_rst), .out_valid(out_valid),
    .out_data(out_data), .out_raw(out_raw), .timeout_err(timeout_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // NLC responder
  int          resp_at = -1;
  logic [20:0] resp_data = '0;
  int          lat = 40;
  logic [20:0] off = 21'd5;
  bit          rand_lat = 1'b0;

  // observations used by the directed checks
  int          n_out = 0, n_iss = 0, n_rst = 0;
  int          last_out_cyc = 0, last_iss_cyc = 0, first_rst_cyc = 0;
  logic [20:0] last_out_data = '0, last_out_raw = '0, last_iss_x = '0;
  bit          last_out_to = 1'b0;
  int          out_cyc_q[$];
  logic [20:0] out_dat_q[$];

  // reference model: queue of accepted samples stamped with the earliest
  // cycle they may be issued, plus timestamps for the in-flight sample
  typedef struct { logic [20:0] d; int avail; } ent_t;
  ent_t        mq[$];
  int          m_drop, m_free_at, m_wait_lo, m_pend_at, m_rst_lo, m_busy_lo, m_busy_hi;
  bit          m_infl, m_pend, m_pto;
  logic [20:0] m_raw, m_last_x, m_pdata, m_praw, m_odata, m_oraw;

  typedef struct {
    logic [20:0] x;
    int          lat;
    logic [20:0] off;
    logic [20:0] exp_data;
    int          exp_cyc;
    bit          exp_to;
  } vec_t;
  vec_t rows[6];

  function automatic void model_reset();
    mq.delete();
    m_drop = 0; m_free_at = cyc; m_wait_lo = 0; m_pend_at = 0;
    m_rst_lo = -10; m_busy_lo = 1; m_busy_hi = 0;
    m_infl = 1'b0; m_pend = 1'b0; m_pto = 1'b0;
    m_raw = '0; m_last_x = '0; m_pdata = '0; m_praw = '0; m_odata = '0; m_oraw = '0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // one clock cycle: drive inputs, compare against the model, advance model
  task automatic step(input bit v, input logic [20:0] d, input bit spur);
    bit          hit, iss, exp_valid, exp_to;
    int          lvl, l;
    logic [20:0] exp_x;
    ent_t        e;
    adc_valid = v;
    adc_data  = d;
    hit       = (cyc == resp_at);
    nlc_srdyo = hit | spur;
    nlc_x_lin = hit ? resp_data : 21'($urandom);
    #1;
    lvl = mq.size();
    iss = 1'b0;
    exp_x = m_last_x;
    if (!m_infl && lvl > 0 && cyc >= m_free_at) begin
      if (cyc >= mq[0].avail) begin
        iss   = 1'b1;
        exp_x = mq[0].d;
      end
    end
    exp_valid = 1'b0;
    exp_to    = 1'b0;
    if (m_pend && cyc == m_pend_at) begin
      exp_valid = 1'b1; exp_to = m_pto; m_odata = m_pdata; m_oraw = m_praw; m_pend = 1'b0;
    end
    chk("in_ready", in_ready, lvl < 8);
    chk("fifo_level", fifo_level, lvl);
    chk("drop_count", drop_count, m_drop);
    chk("nlc_srdyi", nlc_srdyi, iss);
    chk("nlc_x_adc", nlc_x_adc, exp_x);
    chk("nlc_rst", nlc_rst, cyc >= m_rst_lo && cyc <= m_rst_lo + 1);
    chk("out_valid", out_valid, exp_valid);
    chk("out_data", out_data, m_odata);
    chk("out_raw", out_raw, m_oraw);
    chk("timeout_err", timeout_err, exp_to);
    chk("busy", busy, iss || (cyc >= m_busy_lo && cyc <= m_busy_hi));
    if (iss) begin
      m_last_x = mq[0].d; m_raw = mq[0].d;
      void'(mq.pop_front());
      m_infl = 1'b1; m_wait_lo = cyc + 1; m_busy_lo = cyc; m_busy_hi = FAR;
    end else if (m_infl && cyc >= m_wait_lo) begin
      if (nlc_srdyo) begin
        m_pend = 1'b1; m_pend_at = cyc + 1; m_pdata = nlc_x_lin; m_praw = m_raw; m_pto = 1'b0;
        m_infl = 1'b0; m_free_at = cyc + 3; m_busy_hi = cyc + 1;
      end else if (cyc == m_wait_lo + TO) begin
        m_pend = 1'b1; m_pend_at = cyc + 1; m_pdata = m_raw; m_praw = m_raw; m_pto = 1'b1;
        m_infl = 1'b0; m_rst_lo = cyc + 1; m_free_at = cyc + 5; m_busy_hi = cyc + 3;
      end
    end
    if (v) begin
      if (lvl < 8 || iss) begin
        e.d = d; e.avail = cyc + 2;
        mq.push_back(e);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    if (nlc_srdyi) begin
      if (rand_lat) l = ($urandom_range(0, 29) == 0) ? NEVER : int'($urandom_range(1, 60));
      else          l = lat;
      resp_at   = (l < 0) ? -1 : cyc + l;
      resp_data = nlc_x_adc + off;
      n_iss++; last_iss_cyc = cyc; last_iss_x = nlc_x_adc;
    end
    if (out_valid) begin
      n_out++; last_out_cyc = cyc; last_out_data = out_data; last_out_raw = out_raw;
      last_out_to = timeout_err;
      out_cyc_q.push_back(cyc); out_dat_q.push_back(out_data);
    end
    if (nlc_rst) begin
      if (n_rst == 0) first_rst_cyc = cyc;
      n_rst++;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; adc_valid = 1'b0; nlc_srdyo = 1'b0;
    @(posedge clk); #1;
    cyc++;
    reset = 1'b0;
    resp_at = -1;
    model_reset();
  endtask

  task automatic wait_out(input int bound, input string name);
    int n0;
    n0 = n_out;
    for (int i = 0; i < bound && n_out == n0; i++) step(1'b0, '0, 1'b0);
    chk(name, n_out != n0, 1);
  endtask

  task automatic wait_iss(input int bound, input string name);
    int n0;
    n0 = n_iss;
    for (int i = 0; i < bound && n_iss == n0; i++) step(1'b0, '0, 1'b0);
    chk(name, n_iss != n0, 1);
  endtask

  task automatic run_row(input int r);
    vec_t t;
    int   c0;
    t = rows[r];
    lat = t.lat; off = t.off; n_rst = 0; n_iss = 0;
    c0 = cyc;
    step(1'b1, t.x, 1'b0);
    wait_out(1100, $sformatf("row%0d_out_seen", r));
    chk($sformatf("row%0d_issue_dly", r), last_iss_cyc - c0, 2);
    chk($sformatf("row%0d_issue_x", r), last_iss_x, t.x);
    chk($sformatf("row%0d_out_dly", r), last_out_cyc - c0, t.exp_cyc);
    chk($sformatf("row%0d_out_data", r), last_out_data, t.exp_data);
    chk($sformatf("row%0d_out_raw", r), last_out_raw, t.x);
    chk($sformatf("row%0d_timeout_err", r), last_out_to, t.exp_to);
    repeat (6) step(1'b0, '0, 1'b0);
    chk($sformatf("row%0d_rst_cycles", r), n_rst, t.exp_to ? 2 : 0);
    chk($sformatf("row%0d_issue_count", r), n_iss, 1);
  endtask

  initial begin
    int c0, t_out, n0;
    rows[0] = '{21'h00010,  40,    21'd5,      21'h00015,  43,   1'b0};
    rows[1] = '{21'h1FFFFF, 6,     21'd0,      21'h1FFFFF, 9,    1'b0};
    rows[2] = '{21'h1FFFFF, 1,     21'd1,      21'h000000, 4,    1'b0};
    rows[3] = '{21'h0ABCD,  1024,  21'h100000, 21'h10ABCD, 1027, 1'b0};
    rows[4] = '{21'h00777,  NEVER, 21'd0,      21'h00777,  1027, 1'b1};
    rows[5] = '{21'h155555, 1025,  21'd3,      21'h155555, 1027, 1'b1};

    reset = 1'b1; adc_valid = 1'b0; adc_data = '0; nlc_srdyo = 1'b0; nlc_x_lin = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_fifo_level", fifo_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_outputs", {nlc_srdyi, nlc_rst, out_valid, timeout_err}, 0);
    chk("rst_data", {out_data, out_raw}, 0);

    // spurious results while idle
    n0 = n_out;
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    repeat (4) step(1'b0, '0, 1'b0);
    chk("spur_no_out", n_out - n0, 0);
    chk("spur_idle", busy, 0);

    // single-sample transactions
    for (int r = 0; r < 6; r++) run_row(r);

    // burst of 10 into an 8-deep FIFO
    lat = 40; off = 21'd5;
    out_cyc_q.delete(); out_dat_q.delete();
    for (int i = 0; i < 10; i++) begin
      if (i == 8) chk("burst_in_ready_c8", in_ready, 1);
      if (i == 9) chk("burst_in_ready_c9", in_ready, 0);
      step(1'b1, 21'(i + 1), 1'b0);
    end
    chk("burst_drop_count", drop_count, 1);
    for (int i = 0; i < 2000 && out_cyc_q.size() < 9; i++) step(1'b0, '0, 1'b0);
    chk("burst_out_count", out_cyc_q.size(), 9);
    for (int k = 0; k < 9 && k < out_cyc_q.size(); k++) begin
      chk($sformatf("burst_data%0d", k), out_dat_q[k], 21'(k + 6));
      if (k > 0) chk($sformatf("burst_spacing%0d", k), (out_cyc_q[k] - out_cyc_q[k-1]) >= 43, 1);
    end
    repeat (5) step(1'b0, '0, 1'b0);

    // timeout with a second sample queued behind it
    lat = NEVER; off = 21'd5; n_rst = 0;
    c0 = cyc;
    step(1'b1, 21'h00AAA, 1'b0);
    step(1'b1, 21'h00BBB, 1'b0);
    wait_out(1100, "to_out_seen");
    chk("to_out_dly", last_out_cyc - c0, 1027);
    chk("to_out_data", last_out_data, 21'h00AAA);
    chk("to_out_raw", last_out_raw, 21'h00AAA);
    chk("to_timeout_err", last_out_to, 1);
    lat = 5;
    t_out = last_out_cyc;
    wait_iss(10, "to_next_issue_seen");
    chk("to_next_issue_gap", last_iss_cyc - t_out, 4);
    chk("to_next_issue_x", last_iss_x, 21'h00BBB);
    chk("to_rst_cycles", n_rst, 2);
    chk("to_rst_start", first_rst_cyc - t_out, 0);
    wait_out(20, "to_second_out_seen");
    chk("to_second_data", last_out_data, 21'h00BC0);
    chk("to_second_timeout_err", last_out_to, 0);
    repeat (4) step(1'b0, '0, 1'b0);

    // reset while waiting with three samples queued
    lat = NEVER;
    for (int i = 0; i < 4; i++) step(1'b1, 21'(17 * (i + 1)), 1'b0);
    repeat (10) step(1'b0, '0, 1'b0);
    chk("rstq_level_before", fifo_level, 3);
    chk("rstq_busy_before", busy, 1);
    do_reset();
    chk("rstq_level", fifo_level, 0);
    chk("rstq_busy", busy, 0);
    chk("rstq_out_valid", out_valid, 0);
    chk("rstq_drop", drop_count, 0);
    chk("rstq_in_ready", in_ready, 1);
    chk("rstq_out_data", out_data, 0);
    n0 = n_out; n_rst = 0;
    repeat (20) step(1'b0, '0, 1'b0);
    chk("rstq_no_out", n_out - n0, 0);
    chk("rstq_no_rst", n_rst, 0);
    run_row(0);

    // randomized traffic against the model
    rand_lat = 1'b1;
    off = 21'($urandom);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 4, 21'($urandom), $urandom_range(0, 39) == 0);
    chk("rand_drop_saturated", drop_count, 255);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 19) == 0, 21'($urandom), $urandom_range(0, 39) == 0);
    rand_lat = 1'b0; lat = 10;
    repeat (1300) step(1'b0, '0, 1'b0);
    chk("final_fifo_empty", fifo_level, 0);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
